// File: rtl/if_fetch_ctrl_pkg.sv
// rtl/if_fetch_ctrl_pkg.sv - shared word width, state encoding and buffer depth for instruction fetch
// Optional feature macro: SKID_BUF_EN (two-entry fetch buffer instead of one).
package if_fetch_ctrl_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

`ifdef SKID_BUF_EN
    localparam int FIFO_DEPTH = 2;
`else
    localparam int FIFO_DEPTH = 1;
`endif

    localparam int FIFO_CW = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small shift-style fetch buffer, head always at entry 0
// clear has priority over push and pop; overflowing pushes and empty pops are ignored.
module fetch_fifo #(
    parameter int DEPTH = 1,
    parameter int DW    = 64,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [DW-1:0] din,
    output logic [CW-1:0] count,
    output logic [DW-1:0] head
);

    logic [DEPTH*DW-1:0] mem;
    logic [DEPTH*DW-1:0] mem_nxt;
    logic [CW-1:0]       count_nxt;
    logic                push_ok;
    logic                pop_ok;
    int                  widx;

    assign head = mem[DW-1:0];

    always_comb begin
        pop_ok    = pop && (count != '0);
        push_ok   = push && ((count < CW'(DEPTH)) || pop_ok);
        mem_nxt   = pop_ok ? (mem >> DW) : mem;
        widx      = pop_ok ? int'(count) - 1 : int'(count);
        count_nxt = count;
        if (push_ok) begin
            mem_nxt[widx*DW +: DW] = din;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem   <= '0;
            count <= '0;
        end else if (clear) begin
            mem   <= '0;
            count <= '0;
        end else begin
            mem   <= mem_nxt;
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction fetch controller: PC sequencing, branch redirect, fetch buffer
// Buffer depth is 1 by default, 2 when SKID_BUF_EN is defined.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_addr,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic [WORD_WIDTH-1:0] imem_instr,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [WORD_WIDTH-1:0] if_instr,
    output logic [WORD_WIDTH-1:0] if_pc,
    output logic [31:0]           fetch_cnt
);

    fetch_state_t            state;
    logic [WORD_WIDTH-1:0]   pc;
    logic [WORD_WIDTH-1:0]   pc_next;
    logic [FIFO_CW-1:0]      count;
    logic [2*WORD_WIDTH-1:0] head;
    logic                    pop;
    logic                    push;
    logic                    clear;

    assign pc_next   = pc + WORD_WIDTH'(4);
    assign imem_addr = {2'b00, pc[WORD_WIDTH-1:2]};

    // Valid comes only from the registered occupancy, never from if_ready.
    assign if_valid = (count != '0);
    assign if_instr = if_valid ? head[WORD_WIDTH-1:0] : '0;
    assign if_pc    = if_valid ? head[2*WORD_WIDTH-1:WORD_WIDTH] : '0;

    assign pop   = if_valid & if_ready;
    assign clear = branch_taken & (state != ST_IDLE);
    assign push  = (state == ST_RUN) & ~branch_taken
                 & ((count < FIFO_CW'(FIFO_DEPTH)) | pop);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (2*WORD_WIDTH),
        .CW    (FIFO_CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop & ~clear),
        .clear (clear),
        .din   ({pc_next, imem_instr}),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            fetch_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (branch_taken) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!branch_taken) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (clear) begin
                pc <= branch_addr;
            end else if (push) begin
                pc        <= pc_next;
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - scoreboard bench for if_fetch_ctrl against a behavioural fetch model
// Honours SKID_BUF_EN to select the modelled buffer depth.
module tb_if_fetch_ctrl;

`ifdef SKID_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model: 0 idle, 1 running, 2 one-cycle flush bubble.
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    if_fetch_ctrl #(.RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .fetch_cnt    (fetch_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_state = 0;
        m_pc    = 32'h0;
        m_cnt   = 32'h0;
    endtask

    task automatic compare_outputs();
        chk("if_valid", if_valid, sb.size() != 0);
        chk("imem_addr", imem_addr, m_pc >> 2);
        chk("fetch_cnt", fetch_cnt, m_cnt);
        if (sb.size() != 0) begin
            chk("if_pc", if_pc, sb[0][63:32]);
            chk("if_instr", if_instr, sb[0][31:0]);
        end else begin
            chk("if_pc_idle", if_pc, 64'h0);
            chk("if_instr_idle", if_instr, 64'h0);
        end
    endtask

    task automatic model_update(input logic st, input logic br, input logic [31:0] ba,
                                input logic rdy);
        int  n;
        logic p;
        n = sb.size();
        p = (n != 0) && rdy;
        if (m_state != 0 && br) begin
            sb.delete();
            m_pc    = ba;
            m_state = 2;
        end else begin
            if (p) void'(sb.pop_front());
            if (m_state == 1 && (n < DEPTH || p)) begin
                sb.push_back({m_pc + 32'd4, mem_word(m_pc >> 2)});
                m_pc  = m_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
            end
            if (m_state == 0 && st) m_state = 1;
            else if (m_state == 2) m_state = 1;
        end
    endtask

    // Called at a falling edge: drive, check settled outputs, advance one clock.
    task automatic step(input logic st, input logic br, input logic [31:0] ba, input logic rdy);
        start        = st;
        branch_taken = br;
        branch_addr  = ba;
        if_ready     = rdy;
        #1;
        compare_outputs();
        model_update(st, br, ba, rdy);
        @(posedge clk);
        @(negedge clk);
        start        = 1'b0;
        branch_taken = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        if_ready     = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", if_valid, 64'h0);
        chk("rst_imem_addr", imem_addr, 64'h0);
        chk("rst_fetch_cnt", fetch_cnt, 64'h0);
        rst = 1'b0;

        // Streaming with decode always ready.
        step(1'b0, 1'b1, 32'h80, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Decode stall, then release.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Branch while buffer full, then resume.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b0);
        chk("flush_imem_addr", imem_addr, 64'h10);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Branch coincident with a pop of a full buffer; back-to-back branch in flush.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h200, 1'b1);
        step(1'b0, 1'b1, 32'h300, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("pre_rst_occupancy", sb.size(), 64'h1);

        // Asynchronous reset mid-cycle with one buffered instruction.
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", if_valid, 64'h0);
        chk("async_rst_imem_addr", imem_addr, 64'h0);
        chk("async_rst_if_pc", if_pc, 64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h100, 1'b1);

        // PC wrap-around after a branch to the top of the address space.
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        chk("wrap_imem_hi", imem_addr, 64'h3FFF_FFFF);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_imem_zero", imem_addr, 64'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
